// File: rtl/ama_riscv_fwd_scoreboard_pkg.sv
// Shared constants for the forwarding scoreboard: RF-select code, x0 address, select width.
// No logic; no latency; no backpressure.
// Imported by ama_riscv_fwd_match and ama_riscv_fwd_scoreboard.
package ama_riscv_fwd_scoreboard_pkg;

    localparam int FWD_SEL_RF = 0;
    localparam int RF_X0_ZERO = 0;

    // Select code k+1 addresses stage k, 0 means register file.
    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ama_riscv_fwd_match.sv
// Per-source producer lookup: youngest matching in-flight tag wins, flags load-use hazard.
// Latency: purely combinational.
// Backpressure: none; the caller turns hazard into a stall.
module ama_riscv_fwd_match
    import ama_riscv_fwd_scoreboard_pkg::*;
#(
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1,
    parameter int RF_AW     = 5,
    parameter int SW        = 2
) (
    input  logic [RF_AW-1:0]           rs,
    input  logic                       rs_use,
    input  logic [FWD_DEPTH-1:0]       tag_v,
    input  logic [FWD_DEPTH*RF_AW-1:0] tag_rd,
    input  logic [FWD_DEPTH-1:0]       tag_ld,
    output logic [SW-1:0]              sel,
    output logic                       hazard
);

    // Walk oldest to youngest so the lowest matching index is the last write.
    always_comb begin
        sel    = SW'(FWD_SEL_RF);
        hazard = 1'b0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (rs_use && (rs != RF_AW'(RF_X0_ZERO)) && tag_v[k] &&
                (tag_rd[k*RF_AW +: RF_AW] == rs)) begin
                sel    = SW'(k + 1);
                hazard = tag_ld[k] && (k < LOAD_LAT);
            end
        end
    end

endmodule

// File: rtl/ama_riscv_fwd_scoreboard.sv
// Forwarding/hazard unit beside ID; optional statistics under AMA_RISCV_FWD_STATS_EN.
// Latency: fwd_sel/stall combinational from registered tags; tags advance one stage per clk.
// Backpressure: stall holds ID/IF and injects a bubble into stage 0.
module ama_riscv_fwd_scoreboard
    import ama_riscv_fwd_scoreboard_pkg::*;
#(
    parameter  int NUM_SRC   = 2,
    parameter  int FWD_DEPTH = 2,
    parameter  int LOAD_LAT  = 1,
    parameter  int RF_AW     = 5,
    parameter  int CNT_W     = 32,
    localparam int SW        = sel_width(FWD_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic                     id_flush,
    input  logic [NUM_SRC*RF_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]       id_rs_use,
    input  logic [RF_AW-1:0]         id_rd,
    input  logic                     id_we,
    input  logic                     id_load,
    output logic [NUM_SRC*SW-1:0]    fwd_sel,
    output logic                     stall,
    output logic [CNT_W-1:0]         stat_fwd_cnt,
    output logic [CNT_W-1:0]         stat_stall_cnt
);

    if (FWD_DEPTH < 1) begin : g_chk_depth
        $error("FWD_DEPTH must be >= 1");
    end
    if ((LOAD_LAT < 0) || (LOAD_LAT >= FWD_DEPTH)) begin : g_chk_lat
        $error("LOAD_LAT must satisfy 0 <= LOAD_LAT < FWD_DEPTH");
    end
    if (NUM_SRC < 1) begin : g_chk_src
        $error("NUM_SRC must be >= 1");
    end

    typedef struct packed {
        logic             v;
        logic [RF_AW-1:0] rd;
        logic             ld;
    } tag_t;

    tag_t [FWD_DEPTH-1:0]       stage;
    logic [FWD_DEPTH-1:0]       tag_v;
    logic [FWD_DEPTH-1:0]       tag_ld;
    logic [FWD_DEPTH*RF_AW-1:0] tag_rd;
    logic [NUM_SRC-1:0]         hazard;
    logic                       issue;
    logic                       push;

    assign stall = id_valid && !id_flush && (|hazard);
    assign issue = id_valid && !id_flush && !stall;
    assign push  = issue && id_we && (id_rd != RF_AW'(RF_X0_ZERO));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
        end else begin
            stage[0] <= push ? '{v: 1'b1, rd: id_rd, ld: id_load} : '0;
            for (int k = 1; k < FWD_DEPTH; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    always_comb begin
        tag_v  = '0;
        tag_ld = '0;
        tag_rd = '0;
        for (int k = 0; k < FWD_DEPTH; k++) begin
            tag_v[k]                  = stage[k].v;
            tag_ld[k]                 = stage[k].ld;
            tag_rd[k*RF_AW +: RF_AW]  = stage[k].rd;
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [SW-1:0] raw_sel;

        ama_riscv_fwd_match #(
            .FWD_DEPTH (FWD_DEPTH),
            .LOAD_LAT  (LOAD_LAT),
            .RF_AW     (RF_AW),
            .SW        (SW)
        ) u_match (
            .rs     (id_rs[i*RF_AW +: RF_AW]),
            .rs_use (id_rs_use[i]),
            .tag_v  (tag_v),
            .tag_rd (tag_rd),
            .tag_ld (tag_ld),
            .sel    (raw_sel),
            .hazard (hazard[i])
        );

        // A held or killed instruction must not steer the operand muxes.
        assign fwd_sel[i*SW +: SW] = issue ? raw_sel : SW'(FWD_SEL_RF);
    end

`ifdef AMA_RISCV_FWD_STATS_EN
    localparam int IW = CNT_W + $clog2(NUM_SRC + 1);

    logic [CNT_W-1:0] fwd_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [IW-1:0]    fwd_inc;
    logic [IW-1:0]    fwd_nxt;
    logic [IW-1:0]    stall_nxt;

    // fwd_sel is already zero on non-issuing cycles, so no extra qualifier.
    always_comb begin
        fwd_inc = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            fwd_inc = fwd_inc + IW'(fwd_sel[i*SW +: SW] != SW'(FWD_SEL_RF));
        end
        fwd_nxt   = IW'(fwd_cnt) + fwd_inc;
        stall_nxt = IW'(stall_cnt) + IW'(stall);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            fwd_cnt   <= (fwd_nxt > IW'({CNT_W{1'b1}})) ? '1 : fwd_nxt[CNT_W-1:0];
            stall_cnt <= (stall_nxt > IW'({CNT_W{1'b1}})) ? '1 : stall_nxt[CNT_W-1:0];
        end
    end

    assign stat_fwd_cnt   = fwd_cnt;
    assign stat_stall_cnt = stall_cnt;
`else
    assign stat_fwd_cnt   = '0;
    assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ama_riscv_fwd_scoreboard.sv
// Scoreboard bench: default instance plus a FWD_DEPTH=3/LOAD_LAT=2/CNT_W=3 instance.
module tb_ama_riscv_fwd_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_flush, id_we, id_load;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_use;
    logic [4:0]  id_rd;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic [31:0] stat_fwd_cnt, stat_stall_cnt;

    logic        b_valid, b_flush, b_we, b_load;
    logic [9:0]  b_rs;
    logic [1:0]  b_rs_use;
    logic [4:0]  b_rd;
    logic [3:0]  b_fwd_sel;
    logic        b_stall;
    logic [2:0]  b_stat_fwd_cnt, b_stat_stall_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       v, fl;
        logic [4:0] rs0, rs1;
        logic [1:0] u;
        logic [4:0] rd;
        logic       we, ld;
        logic [3:0] sel;
        logic       stl;
    } row_t;

    typedef struct packed {
        logic [3:0] sel;
        logic       stl;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    ama_riscv_fwd_scoreboard dut (
        .clk (clk), .rst_n (rst_n), .id_valid (id_valid), .id_flush (id_flush),
        .id_rs (id_rs), .id_rs_use (id_rs_use), .id_rd (id_rd), .id_we (id_we),
        .id_load (id_load), .fwd_sel (fwd_sel), .stall (stall),
        .stat_fwd_cnt (stat_fwd_cnt), .stat_stall_cnt (stat_stall_cnt)
    );

    ama_riscv_fwd_scoreboard #(.NUM_SRC(2), .FWD_DEPTH(3), .LOAD_LAT(2), .RF_AW(5), .CNT_W(3)) dut_b (
        .clk (clk), .rst_n (rst_n), .id_valid (b_valid), .id_flush (b_flush),
        .id_rs (b_rs), .id_rs_use (b_rs_use), .id_rd (b_rd), .id_we (b_we),
        .id_load (b_load), .fwd_sel (b_fwd_sel), .stall (b_stall),
        .stat_fwd_cnt (b_stat_fwd_cnt), .stat_stall_cnt (b_stat_stall_cnt)
    );

    function automatic row_t mk(input int v, fl, rs0, rs1, u, rd, we, ld, sel, stl);
        row_t r;
        r.v = 1'(v);     r.fl = 1'(fl);   r.rs0 = 5'(rs0); r.rs1 = 5'(rs1);
        r.u = 2'(u);     r.rd = 5'(rd);   r.we = 1'(we);   r.ld = 1'(ld);
        r.sel = 4'(sel); r.stl = 1'(stl);
        return r;
    endfunction

    function automatic row_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic drive(input row_t r);
        @(posedge clk);
        #1;
        id_valid = r.v;  id_flush = r.fl; id_rs = {r.rs1, r.rs0}; id_rs_use = r.u;
        id_rd = r.rd;    id_we = r.we;    id_load = r.ld;
    endtask

    task automatic drive_b(input row_t r);
        @(posedge clk);
        #1;
        b_valid = r.v;   b_flush = r.fl;  b_rs = {r.rs1, r.rs0}; b_rs_use = r.u;
        b_rd = r.rd;     b_we = r.we;     b_load = r.ld;
    endtask

    function automatic exp_t to_exp(input row_t r);
        exp_t e;
        e.sel = r.sel;
        e.stl = r.stl;
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        id_valid = 1'b1; id_flush = 1'b0; id_rs = {5'd5, 5'd5}; id_rs_use = 2'b11;
        id_rd = 5'd5; id_we = 1'b1; id_load = 1'b1;
        b_valid = 1'b1; b_flush = 1'b0; b_rs = {5'd5, 5'd5}; b_rs_use = 2'b11;
        b_rd = 5'd5; b_we = 1'b1; b_load = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (fwd_sel !== 4'b0000 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_out got sel=%b stall=%b want sel=0000 stall=0", fwd_sel, stall);
        end
        checks++;
        if (stat_fwd_cnt !== 32'd0 || stat_stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_stats got fwd=%0d stall=%0d want 0 0", stat_fwd_cnt, stat_stall_cnt);
        end
        checks++;
        if (b_fwd_sel !== 4'b0000 || b_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_b got sel=%b stall=%b want sel=0000 stall=0", b_fwd_sel, b_stall);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        id_valid = 1'b0; id_rs_use = 2'b00; id_we = 1'b0; id_load = 1'b0;
        b_valid = 1'b0;  b_rs_use = 2'b00;  b_we = 1'b0;  b_load = 1'b0;
    endtask

    task automatic run_rows(input string name, input row_t rows[$]);
        exp_t e;
        foreach (rows[j]) begin
            drive(rows[j]);
            q.push_back(to_exp(rows[j]));
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (fwd_sel !== e.sel || stall !== e.stl) begin
                errors++;
                $display("FAIL %s[%0d] got sel=%b stall=%b want sel=%b stall=%b",
                         name, j, fwd_sel, stall, e.sel, e.stl);
            end
        end
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        rows.push_back(mk(1, 0, 1, 2, 3, 5, 1, 0, 4'b0000, 0));   // add x5,x1,x2
        rows.push_back(mk(1, 0, 5, 5, 3, 6, 1, 0, 4'b0101, 0));   // add x6,x5,x5
        rows.push_back(idle());
        rows.push_back(idle());
        run_rows("back_to_back", rows);
    endtask

    task automatic test_mem_fwd();
        row_t rows[$];
        rows.push_back(mk(1, 0, 1, 2, 3, 5, 1, 0, 4'b0000, 0));   // add x5
        rows.push_back(mk(1, 0, 3, 4, 3, 9, 1, 0, 4'b0000, 0));   // add x9
        rows.push_back(mk(1, 0, 5, 0, 3, 7, 1, 0, 4'b0010, 0));   // sub x7,x5,x0
        rows.push_back(idle());
        rows.push_back(idle());
        run_rows("mem_fwd", rows);
    endtask

    task automatic test_load_use();
        row_t rows[$];
        rows.push_back(mk(1, 0, 2, 0, 1, 7, 1, 1, 4'b0000, 0));   // lw x7
        rows.push_back(mk(1, 0, 7, 8, 3, 8, 1, 0, 4'b0000, 1));   // add x8,x7,x8 stalls
        rows.push_back(mk(1, 0, 7, 8, 3, 8, 1, 0, 4'b0010, 0));   // held copy; x8 must not be tracked
        rows.push_back(idle());
        rows.push_back(idle());
        run_rows("load_use", rows);
    endtask

    task automatic test_stats();
        int ef, es;
        ef = 0;
        es = 0;
`ifdef AMA_RISCV_FWD_STATS_EN
        ef = 4;
        es = 1;
`endif
        @(negedge clk);
        checks++;
        if (stat_fwd_cnt !== 32'(ef)) begin
            errors++;
            $display("FAIL stat_fwd got %0d want %0d", stat_fwd_cnt, ef);
        end
        checks++;
        if (stat_stall_cnt !== 32'(es)) begin
            errors++;
            $display("FAIL stat_stall got %0d want %0d", stat_stall_cnt, es);
        end
    endtask

    task automatic test_x0_and_use();
        row_t rows[$];
        rows.push_back(mk(1, 0, 1, 0, 1, 0, 1, 0, 4'b0000, 0));   // addi x0
        rows.push_back(mk(1, 0, 0, 0, 3, 6, 1, 0, 4'b0000, 0));   // add x6,x0,x0
        rows.push_back(idle());
        rows.push_back(idle());
        rows.push_back(mk(1, 0, 1, 0, 1, 5, 1, 0, 4'b0000, 0));   // addi x5
        rows.push_back(mk(1, 0, 5, 5, 2, 6, 1, 0, 4'b0100, 0));   // src0 unused, src1 used
        rows.push_back(idle());
        rows.push_back(idle());
        rows.push_back(mk(1, 0, 1, 0, 1, 5, 1, 0, 4'b0000, 0));   // addi x5
        rows.push_back(mk(1, 0, 2, 0, 1, 5, 1, 0, 4'b0000, 0));   // addi x5
        rows.push_back(mk(1, 0, 5, 5, 3, 6, 1, 0, 4'b0101, 0));   // youngest wins
        rows.push_back(idle());
        rows.push_back(idle());
        run_rows("x0_use", rows);
    endtask

    task automatic test_flush();
        row_t rows[$];
        rows.push_back(mk(1, 0, 2, 0, 1, 7, 1, 1, 4'b0000, 0));   // lw x7
        rows.push_back(mk(1, 1, 7, 0, 1, 7, 1, 0, 4'b0000, 0));   // flushed dependent
        rows.push_back(mk(1, 0, 7, 0, 1, 9, 1, 0, 4'b0010, 0));   // bubble in stage 0
        rows.push_back(idle());
        rows.push_back(idle());
        run_rows("flush", rows);
    endtask

    task automatic test_load_lat2();
        exp_t e;
        row_t rows[$];
        int   ef, es;
        for (int rep = 0; rep < 4; rep++) begin
            rows.push_back(mk(1, 0, 2, 0, 1, 7, 1, 1, 4'b0000, 0));
            rows.push_back(mk(1, 0, 7, 0, 3, 8, 1, 0, 4'b0000, 1));
            rows.push_back(mk(1, 0, 7, 0, 3, 8, 1, 0, 4'b0000, 1));
            rows.push_back(mk(1, 0, 7, 0, 3, 8, 1, 0, 4'b0011, 0));
        end
        foreach (rows[j]) begin
            drive_b(rows[j]);
            q.push_back(to_exp(rows[j]));
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (b_fwd_sel !== e.sel || b_stall !== e.stl) begin
                errors++;
                $display("FAIL load_lat2[%0d] got sel=%b stall=%b want sel=%b stall=%b",
                         j, b_fwd_sel, b_stall, e.sel, e.stl);
            end
        end
        drive_b(idle());
        ef = 0;
        es = 0;
`ifdef AMA_RISCV_FWD_STATS_EN
        ef = 4;
        es = 7;
`endif
        @(negedge clk);
        checks++;
        if (b_stat_fwd_cnt !== 3'(ef) || b_stat_stall_cnt !== 3'(es)) begin
            errors++;
            $display("FAIL stat_sat got fwd=%0d stall=%0d want fwd=%0d stall=%0d",
                     b_stat_fwd_cnt, b_stat_stall_cnt, ef, es);
        end
    endtask

    task automatic test_reset_mid();
        row_t rows[$];
        rows.push_back(mk(1, 0, 2, 0, 1, 7, 1, 1, 4'b0000, 0));   // lw x7
        rows.push_back(mk(1, 0, 7, 0, 1, 8, 1, 0, 4'b0000, 1));   // dependent stalls
        run_rows("reset_mid_pre", rows);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (fwd_sel !== 4'b0000 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got sel=%b stall=%b want sel=0000 stall=0", fwd_sel, stall);
        end
        checks++;
        if (stat_fwd_cnt !== 32'd0 || stat_stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_stats got fwd=%0d stall=%0d want 0 0", stat_fwd_cnt, stat_stall_cnt);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (fwd_sel !== 4'b0000 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_lost got sel=%b stall=%b want sel=0000 stall=0", fwd_sel, stall);
        end
        drive(idle());
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_mem_fwd();
        test_load_use();
        test_stats();
        test_x0_and_use();
        test_flush();
        test_load_lat2();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
